// File: rtl/prim_2sync_pkg.sv
// Shared constants for the multi-bit flop synchronizer.
// PRIM_2SYNC_EXTRA_STAGE_EN adds a third synchronizer stage (latency 3 instead of 2).
package prim_2sync_pkg;

`ifdef PRIM_2SYNC_EXTRA_STAGE_EN
  localparam int unsigned NumStages = 3;
`else
  localparam int unsigned NumStages = 2;
`endif

  localparam int unsigned DefaultWidth = 16;

endpackage

// File: rtl/prim_2sync_stage.sv
// One Width-wide synchronizer stage: a plain flop bank with async active-high reset.
module prim_2sync_stage
  import prim_2sync_pkg::*;
#(
  parameter int unsigned     Width      = DefaultWidth,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // Kept separate and un-retimed so each bit sees a full cycle to resolve metastability.
  (* ASYNC_REG = "TRUE" *) (* keep = "true" *) logic [Width-1:0] q_q;
  logic [Width-1:0] q_d;

  always_comb q_d = d_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= ResetValue;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/prim_2flop_sync.sv
// Per-bit flop synchronizer into clk_i; a chain of NumStages stages, q_o straight from the last flop.
// PRIM_2SYNC_EXTRA_STAGE_EN (via prim_2sync_pkg) selects a 3-stage chain.
module prim_2flop_sync
  import prim_2sync_pkg::*;
#(
  parameter int unsigned      Width      = DefaultWidth,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] chain [NumStages+1];

  assign chain[0] = d_i;

  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    prim_2sync_stage #(
      .Width      (Width),
      .ResetValue (ResetValue)
    ) u_stage (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (chain[s]),
      .q_o   (chain[s+1])
    );
  end

  assign q_o = chain[NumStages];

`ifndef SYNTHESIS
  // Edges since reset release, saturating once the whole chain holds post-reset data.
  localparam logic [1:0] WarmMax = 2'(NumStages);
  logic [1:0] warm_q, warm_d;

  always_comb begin
    warm_d = warm_q;
    if (warm_q != WarmMax) warm_d = warm_q + 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) warm_q <= 2'd0;
    else       warm_q <= warm_d;
  end

  a_reset_value : assert property (@(posedge clk_i) rst_i |-> (q_o == ResetValue));

  a_latency : assert property (@(posedge clk_i) disable iff (rst_i)
    (warm_q == WarmMax) |-> (q_o == $past(d_i, NumStages)));
`endif

endmodule

// File: tb/tb_prim_2flop_sync.sv
// Bench for prim_2flop_sync: table vectors, hand corner sequences and random traffic vs. a delay-line model.
module tb_prim_2flop_sync;
  import prim_2sync_pkg::*;

  localparam int unsigned     W  = 16;
  localparam logic [W-1:0]    RV = 16'hA5A5;
  localparam int              N  = int'(NumStages);

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] d_i;
  logic [W-1:0] q_o;

  int errors = 0;
  int checks = 0;

  // Reference: every value sampled since reset release; output is the one N samples back.
  logic [W-1:0] hist [$];

  typedef struct {
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl [$];

  always #5 clk_i = ~clk_i;

  prim_2flop_sync #(
    .Width      (W),
    .ResetValue (RV)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (d_i),
    .q_o   (q_o)
  );

  function automatic logic [W-1:0] model_q();
    if (hist.size() >= N) return hist[hist.size()-N];
    return RV;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_i) hist.delete();
    else       hist.push_back(d_i);
    #1;
  endtask

  task automatic settle(input logic [W-1:0] v);
    d_i = v;
    repeat (N + 1) tick();
  endtask

  initial begin
    logic [W-1:0] prev;
    int           pulse_seen;

    rst_i = 1'b1;
    d_i   = 16'h1234;
    #2;
    chk("reset_state", q_o, RV);

    // Reset release with d=1234
    tbl.push_back('{1'b1, 16'h1234, RV});
    for (int k = 1; k <= 4; k++)
      tbl.push_back('{1'b0, 16'h1234, (k >= N) ? 16'h1234 : RV});
    // Latency step 0 -> FFFF
    tbl.push_back('{1'b1, 16'h0000, RV});
    for (int k = 1; k <= 3; k++)
      tbl.push_back('{1'b0, 16'h0000, (k >= N) ? 16'h0000 : RV});
    for (int k = 1; k <= 4; k++)
      tbl.push_back('{1'b0, 16'hFFFF, (k >= N) ? 16'hFFFF : 16'h0000});
    // Streaming 1,2,3,4 then hold 4
    for (int j = 1; j <= 9; j++) begin
      int dv, ev;
      dv = (j <= 4) ? j : 4;
      ev = (j - N + 1 <= 4) ? (j - N + 1) : 4;
      tbl.push_back('{1'b0, 16'(dv), (j >= N) ? 16'(ev) : 16'hFFFF});
    end

    foreach (tbl[i]) begin
      rst_i = tbl[i].rst;
      d_i   = tbl[i].d;
      if (tbl[i].rst) hist.delete();
      tick();
      chk($sformatf("vec%0d", i), q_o, tbl[i].exp);
    end

    // Mid-run reset between edges: output must drop with no clock edge.
    settle(16'h00FF);
    chk("pre_rst", q_o, 16'h00FF);
    @(negedge clk_i);
    rst_i = 1'b1;
    hist.delete();
    #1;
    chk("async_rst", q_o, RV);
    #1;
    rst_i = 1'b0;
    for (int k = 1; k <= N; k++) begin
      tick();
      chk("rst_rerelease", q_o, (k >= N) ? 16'h00FF : RV);
    end

    // Single-cycle pulse must come out as exactly one cycle.
    settle(16'h0000);
    d_i = 16'h0008;
    tick();
    d_i = 16'h0000;
    pulse_seen = 0;
    for (int k = 0; k < N + 3; k++) begin
      if (q_o == 16'h0008) pulse_seen++;
      chk("pulse", q_o, model_q());
      tick();
    end
    chk("pulse_width", 16'(pulse_seen), 16'd1);

    // 5-bit gray walk: at most one bit change per cycle on q_o.
    settle(16'h0000);
    prev = q_o;
    for (int i = 0; i < 40; i++) begin
      int g;
      g   = i % 32;
      d_i = 16'(g ^ (g >> 1));
      tick();
      chk("gray", q_o, model_q());
      chk("gray_step", 16'($countones(q_o ^ prev) <= 1), 16'd1);
      prev = q_o;
    end

    // Random data with occasional asynchronous reset pulses.
    for (int i = 0; i < 300; i++) begin
      d_i = 16'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk_i);
        rst_i = 1'b1;
        hist.delete();
        #1;
        chk("rand_rst", q_o, RV);
        rst_i = 1'b0;
      end
      tick();
      chk("rand", q_o, model_q());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
